regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file, successor to the fixed 8x32 two-read file.
//  Adds configurable width/depth/read ports, write-to-read bypass, hardwired-zero R0,
//  a per-entry pending-write scoreboard and a sequenced clear engine (reset or on request).
//  Sits in the CPU decode/writeback path: decode reads operands and checks hazards,
//  writeback writes results.
// PARAMETERS
//  DW          32  data width in bits
//  DEPTH       32  number of entries; power of 2, >= 2
//  AW          $clog2(DEPTH)  address width (derived localparam, not overridable)
//  NUM_READ    2   number of read ports, 1..4
//  ZERO_R0     1   1: entry 0 reads 0, ignores writes, is never pending
//  BYPASS      1   1: same-cycle write data is forwarded to matching read ports
//  INIT_INDEX  1   1: clear loads entry i with value i (zero-extended); 0: loads 0
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             synchronous active-high reset
//  clear_req    in   1             pulse: start clear sequence (accepted only when !busy)
//  busy         out  1             clear sequence in progress
//  rr_addr      in   NUM_READ*AW   read addresses; port k = bits [k*AW +: AW]
//  rd_data      out  NUM_READ*DW   read data; port k = bits [k*DW +: DW]
//  rd_pending   out  NUM_READ      port k: entry rr_addr[k] has an outstanding write
//  reg_write    in   1             write enable
//  wr_addr      in   AW            write address
//  wr_data      in   DW            write data
//  issue_valid  in   1             mark issue_addr pending (producer issued)
//  issue_addr   in   AW            entry to mark pending
// BEHAVIOUR
//  - Reset: while rst=1, FSM held in CLEAR with clr_idx=0, busy=1, all pending bits 0.
//    rd_data=0, rd_pending=0 while busy. Storage contents undefined until clear completes.
//  - FSM states IDLE, CLEAR. In CLEAR (rst=0), each cycle writes init value to entry clr_idx, then increments it;
//    after clr_idx=DEPTH-1 is written, state goes IDLE on that edge. busy=0 from the next cycle,
//    i.e. DEPTH cycles after rst falls. clear_req in IDLE -> CLEAR, clr_idx=0, pending bits cleared same edge.
//  - clear_req while busy: ignored. rst during CLEAR: restart at clr_idx=0.
//  - While busy: reg_write and issue_valid ignored (no storage or scoreboard change).
//  - Write: on posedge, if reg_write & !busy & !(ZERO_R0 & wr_addr==0): mem[wr_addr] <= wr_data.
//  - Read: combinational, zero latency. Port k: if busy -> 0; else if ZERO_R0 & addr==0 -> 0;
//    else if BYPASS & effective write to same addr this cycle -> wr_data; else mem[addr].
//    BYPASS=0: read returns old value in write cycle, new value next cycle.
//  - Scoreboard: pending[i] set on posedge by issue_valid & !busy & issue_addr==i;
//    cleared by effective write to i. Set and clear of same entry same cycle -> set wins
//    (newer producer). ZERO_R0: pending[0] forced 0.
//  - rd_pending[k] = pending[rr_addr[k]] (registered bit, combinational lookup; no bypass of
//    same-cycle write clear).
//  - INIT_INDEX value: i truncated to DW bits if DW < AW. With ZERO_R0, entry 0 reads 0 regardless.
//  - No X on outputs once busy=0; all outputs defined from first rst cycle.
// STRUCTURE
//  - Package regfile_pkg: FSM state enum (RF_IDLE, RF_CLEAR), max NUM_READ constant,
//    function init_value(idx, INIT_INDEX).
//  - Sub-module rf_clear_fsm: owns state, clr_idx counter, busy, clear write strobe/address;
//    top mux selects clear write port vs functional write port.
//  - Read ports via generate loop; storage as reg array, single write port.
// TESTING
//  - Reset: rst=1 for 3 cycles, release -> busy=1 for exactly DEPTH (32) cycles, then 0;
//    read addr 5 -> 5 (INIT_INDEX=1), addr 0 -> 0.
//  - Write/read: write 0xDEADBEEF to 7; same cycle port0 addr 7 -> 0xDEADBEEF (BYPASS=1);
//    rebuild BYPASS=0 -> 0x7 same cycle, 0xDEADBEEF next cycle.
//  - R0: write 0x1234 to 0 -> all ports read 0; issue_valid addr 0 -> rd_pending stays 0.
//  - Scoreboard: issue 9 -> next cycle rd_pending=1 on port reading 9; write 9 -> cleared next
//    cycle; issue 9 and write 9 same cycle -> pending remains 1, mem[9] updated.
//  - Clear mid-use: write 0xAA to 3, clear_req -> busy 32 cycles, reads 0 during busy, writes
//    ignored; after, addr 3 -> 3; clear_req during busy has no effect on duration.
//  - rst asserted at clr_idx=10 -> busy stays 1, full 32-cycle clear restarts after rst falls.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, limits and the clear-value helper for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int MAX_NUM_READ = 4;

  // Value loaded into entry idx by the clear engine; the caller truncates or
  // zero-extends to its data width.
  function automatic logic [31:0] init_value(input logic [31:0] idx, input logic init_index);
    return init_index ? idx : 32'd0;
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear sequencer: walks every entry once after reset or on request.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RF_IDLE  | storage valid, functional reads/writes allowed
//   RF_CLEAR | writing init value to entry clr_idx, one entry per cycle
module rf_clear_fsm #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic          clr_start_o,
  output logic [AW-1:0] clr_idx_o
);
  import regfile_pkg::*;

  rf_state_e     state_q;
  logic [AW-1:0] clr_idx_q;
  logic          busy_q;

  // State, index and busy flag; reset parks in CLEAR at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (clear_req_i) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        RF_CLEAR: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_q <= RF_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= RF_CLEAR;
          clr_idx_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // rst is folded into busy so the outputs are defined before the first edge.
  assign busy_o      = busy_q | rst;
  assign clr_we_o    = (state_q == RF_CLEAR) & ~rst;
  assign clr_start_o = (state_q == RF_IDLE) & clear_req_i & ~rst;
  assign clr_idx_o   = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with bypass, hardwired R0,
// pending-write scoreboard and a sequenced clear engine.
module regfile_mp #(
  parameter  int DW         = 32,
  parameter  int DEPTH      = 32,
  parameter  int NUM_READ   = 2,
  parameter  int ZERO_R0    = 1,
  parameter  int BYPASS     = 1,
  parameter  int INIT_INDEX = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic [0:0]           clk,
  input  logic                 rst,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic [NUM_READ*AW-1:0] rr_addr,
  output logic [NUM_READ*DW-1:0] rd_data,
  output logic [NUM_READ-1:0]    rd_pending,
  input  logic                 reg_write,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_addr
);
  import regfile_pkg::*;

  if (NUM_READ < 1 || NUM_READ > MAX_NUM_READ) begin : g_bad_num_read
    $error("regfile_mp: NUM_READ out of range");
  end

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;

  logic          clr_we;
  logic          clr_start;
  logic [AW-1:0] clr_idx;
  logic [DW-1:0] clr_wdata;
  logic          wr_eff;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  rf_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear (
    .clk         (clk),
    .rst         (rst),
    .clear_req_i (clear_req),
    .busy_o      (busy),
    .clr_we_o    (clr_we),
    .clr_start_o (clr_start),
    .clr_idx_o   (clr_idx)
  );

  // A functional write only counts when idle and not aimed at a hardwired R0.
  assign wr_eff    = reg_write & ~busy & ~((ZERO_R0 != 0) && (wr_addr == '0));
  assign clr_wdata = DW'(init_value(32'(clr_idx), INIT_INDEX != 0));

  // Clear and functional writes are mutually exclusive (busy blocks the latter).
  assign mem_we    = clr_we | wr_eff;
  assign mem_waddr = clr_we ? clr_idx : wr_addr;
  assign mem_wdata = clr_we ? clr_wdata : wr_data;

  // Single write port into storage; contents are only meaningful after a clear.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Pending scoreboard: a new issue beats a retiring write to the same entry.
  always_ff @(posedge clk) begin
    if (rst || clr_start) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_eff && (wr_addr == AW'(i))) begin
          pend_q[i] <= 1'b0;
        end
        if (issue_valid && !busy && (issue_addr == AW'(i))) begin
          pend_q[i] <= 1'b1;
        end
      end
      if (ZERO_R0 != 0) begin
        pend_q[0] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] rdat;

    assign addr = rr_addr[k*AW +: AW];

    // Zero-latency read with optional same-cycle write forwarding.
    always_comb begin
      rdat = '0;
      if (busy) begin
        rdat = '0;
      end else if ((ZERO_R0 != 0) && (addr == '0)) begin
        rdat = '0;
      end else if ((BYPASS != 0) && wr_eff && (wr_addr == addr)) begin
        rdat = wr_data;
      end else begin
        rdat = mem_q[addr];
      end
    end

    assign rd_data[k*DW +: DW] = rdat;
    assign rd_pending[k]       = ~busy & pend_q[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clear_req, reg_write, issue_valid;
  logic [AW-1:0]    wr_addr, issue_addr;
  logic [DW-1:0]    wr_data;
  logic [NR*AW-1:0] rr_addr;
  logic             busy_b, busy_n;
  logic [NR*DW-1:0] rd_b, rd_n;
  logic [NR-1:0]    pend_b, pend_n;

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_READ(NR), .ZERO_R0(1), .BYPASS(1), .INIT_INDEX(1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_b),
    .rr_addr(rr_addr), .rd_data(rd_b), .rd_pending(pend_b),
    .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr)
  );

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_READ(NR), .ZERO_R0(1), .BYPASS(0), .INIT_INDEX(1)) dut_nb (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_n),
    .rr_addr(rr_addr), .rd_data(rd_n), .rd_pending(pend_n),
    .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr)
  );

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0b;
    logic [31:0] rd1b;
    logic [31:0] rd0n;
    logic [31:0] rd1n;
    logic        p0;
    logic        p1;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[16];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return rd_b[31:0];
      1:       return rd_b[63:32];
      2:       return rd_n[31:0];
      3:       return rd_n[63:32];
      4:       return 32'(pend_b[0]);
      5:       return 32'(pend_b[1]);
      6:       return 32'(pend_n[0]);
      7:       return 32'(pend_n[1]);
      8:       return 32'(busy_b);
      default: return 32'(busy_n);
    endcase
  endfunction

  task automatic push(input string nm, input int sel, input logic [31:0] exp);
    sb_t e;
    e.nm  = nm;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp(e.nm, actual(e.sel), e.exp);
    end
  endtask

  task automatic push_all(input string nm, input logic [31:0] rd0b, input logic [31:0] rd1b,
                          input logic [31:0] rd0n, input logic [31:0] rd1n,
                          input logic p0, input logic p1, input logic bsy);
    push({nm, " rd0 byp"}, 0, rd0b);
    push({nm, " rd1 byp"}, 1, rd1b);
    push({nm, " rd0 nobyp"}, 2, rd0n);
    push({nm, " rd1 nobyp"}, 3, rd1n);
    push({nm, " pend0 byp"}, 4, 32'(p0));
    push({nm, " pend1 byp"}, 5, 32'(p1));
    push({nm, " pend0 nobyp"}, 6, 32'(p0));
    push({nm, " pend1 nobyp"}, 7, 32'(p1));
    push({nm, " busy byp"}, 8, 32'(bsy));
    push({nm, " busy nobyp"}, 9, 32'(bsy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req   = 1'b0;
    reg_write   = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  // Counts busy cycles of both instances; poke_at >= 0 injects a write, an issue
  // and a repeated clear request on that busy cycle, all of which must be ignored.
  task automatic count_busy(input string nm, input int poke_at);
    int nb = 0;
    int nn = 0;
    bit zero_ok = 1'b1;
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (c == poke_at) begin
        reg_write   = 1'b1;
        wr_addr     = 5'd3;
        wr_data     = 32'h0000_00BB;
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        clear_req   = 1'b1;
        rr_addr     = {5'd4, 5'd3};
      end else if (c == poke_at + 1) begin
        idle_inputs();
      end
      #4;
      if (busy_b === 1'b1) begin
        nb++;
        if (rd_b !== '0 || pend_b !== '0) zero_ok = 1'b0;
      end
      if (busy_n === 1'b1) begin
        nn++;
        if (rd_n !== '0 || pend_n !== '0) zero_ok = 1'b0;
      end
      if (busy_b !== 1'b1 && busy_n !== 1'b1) done = 1'b1;
      step();
    end
    idle_inputs();
    cmp({nm, " busy cycles byp"}, 32'(nb), 32'(DEPTH));
    cmp({nm, " busy cycles nobyp"}, 32'(nn), 32'(DEPTH));
    cmp({nm, " outputs zero while busy"}, 32'(zero_ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // we wa wd iv ia ra0 ra1 | rd0b rd1b rd0n rd1n p0 p1
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd0,  32'd5,        32'd0,        32'd5,        32'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'd7,        32'd7,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd6,  32'hDEADBEEF, 32'd6,        32'hDEADBEEF, 32'd6,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0, 5'd0,  5'd0,  32'd0,        32'd0,        32'd0,        32'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'd0,        32'd0,        32'd0,        32'd0,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9,  5'd9,  32'd9,        32'd9,        32'd9,        32'd9,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd1,  32'd9,        32'd1,        32'd9,        32'd1,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd9,  32'h55,       1'b0, 5'd0, 5'd9,  5'd9,  32'h55,       32'h55,       32'd9,        32'd9,  1'b1, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'h55,       32'h55,       32'h55,       32'h55, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9,  5'd9,  32'h55,       32'h55,       32'h55,       32'h55, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd9,  32'h66,       1'b1, 5'd9, 5'd9,  5'd9,  32'h66,       32'h66,       32'h55,       32'h55, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'h66,       32'h66,       32'h66,       32'h66, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 5'd9,  32'h77,       1'b0, 5'd0, 5'd9,  5'd31, 32'h77,       32'd31,       32'h66,       32'd31, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd31, 32'h77,       32'd31,       32'h77,       32'd31, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd31, 5'd30, 32'hFFFFFFFF, 32'd30,       32'd31,       32'd30, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd3,  32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 32'd3,  1'b0, 1'b0};

    // Reset held for three cycles: busy, zero reads, nothing pending.
    rst = 1'b1;
    idle_inputs();
    rr_addr = {5'd0, 5'd5};
    for (int c = 0; c < 3; c++) begin
      #4;
      push_all($sformatf("reset c%0d", c), 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      check_sb();
      step();
    end
    rst = 1'b0;
    count_busy("post-reset clear", -1);

    for (int v = 0; v < 16; v++) begin
      reg_write   = vecs[v].we;
      wr_addr     = vecs[v].wa;
      wr_data     = vecs[v].wd;
      issue_valid = vecs[v].iv;
      issue_addr  = vecs[v].ia;
      rr_addr     = {vecs[v].ra1, vecs[v].ra0};
      push_all($sformatf("vec%0d", v), vecs[v].rd0b, vecs[v].rd1b, vecs[v].rd0n, vecs[v].rd1n,
               vecs[v].p0, vecs[v].p1, 1'b0);
      #4;
      check_sb();
      step();
    end
    idle_inputs();

    // Clear mid-use: write 0xAA to 3 and issue 9, then request a clear.
    reg_write   = 1'b1;
    wr_addr     = 5'd3;
    wr_data     = 32'hAA;
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    rr_addr     = {5'd9, 5'd3};
    push_all("pre-clear write", 32'hAA, 32'h77, 32'd3, 32'h77, 1'b0, 1'b0, 1'b0);
    #4;
    check_sb();
    step();
    idle_inputs();
    clear_req = 1'b1;
    push_all("clear request", 32'hAA, 32'h77, 32'hAA, 32'h77, 1'b0, 1'b1, 1'b0);
    #4;
    check_sb();
    step();
    clear_req = 1'b0;
    count_busy("requested clear", 20);
    rr_addr = {5'd9, 5'd3};
    push_all("after clear a", 32'd3, 32'd9, 32'd3, 32'd9, 1'b0, 1'b0, 1'b0);
    #4;
    check_sb();
    step();
    rr_addr = {5'd31, 5'd4};
    push_all("after clear b", 32'd4, 32'd31, 32'd4, 32'd31, 1'b0, 1'b0, 1'b0);
    #4;
    check_sb();
    step();

    // Reset arriving at clr_idx=10 restarts the full walk.
    reg_write = 1'b1;
    wr_addr   = 5'd20;
    wr_data   = 32'h12;
    rr_addr   = {5'd20, 5'd20};
    push_all("write 20", 32'h12, 32'h12, 32'd20, 32'd20, 1'b0, 1'b0, 1'b0);
    #4;
    check_sb();
    step();
    idle_inputs();
    clear_req = 1'b1;
    #4;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      push_all($sformatf("rst mid-clear c%0d", c), 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      check_sb();
      step();
    end
    rst = 1'b0;
    count_busy("restarted clear", -1);
    rr_addr = {5'd20, 5'd20};
    push_all("after restart", 32'd20, 32'd20, 32'd20, 32'd20, 1'b0, 1'b0, 1'b0);
    #4;
    check_sb();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
